uart_tx: RTL and testbench

UART transmitter: the outgoing half of the board's serial link, matched to the existing 8N1 receiver at 1085 clocks per bit (115200 baud from a 125 MHz clock). It accepts bytes over a valid/ready handshake, buffers them in a small FIFO and serialises each one LSB-first onto `txd`. Its intended use is echoing or acknowledging the received LED-command characters (`r`, `g`, `b`) back to the host.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   // Line state machine encoding, shared so both directions decode alike
   typedef enum logic [1:0] {
      IDLE_ST  = 2'd0,
      START_ST = 2'd1,
      DATA_ST  = 2'd2,
      STOP_ST  = 2'd3
   } uart_state_t;

   // 115200 baud from a 125 MHz clock
   localparam int UART_CLKS_PER_BIT = 1085;

   // 8N1 framing: eight data bits, no parity, one stop bit
   localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO buffering bytes ahead of the serialiser.
// Latency: a pushed entry is visible on rdata/empty the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored internally.
module uart_tx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   // Full/empty come straight from the registered count, so a push on the
   // same edge as a pop from a full FIFO is still refused.
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: buffers bytes in a small FIFO and shifts them out LSB first on txd.
// Latency: byte pushed on edge E pops on E+1 with the start bit driven from E+1; frame is 10 bit times.
// Backpressure: tx_ready = !full from registered count; producer holds tx_data while tx_ready is low.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          txd,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   uart_state_t                state;
   logic [CNT_W-1:0]           clk_cnt;
   logic [2:0]                 bit_idx;
   logic [UART_DATA_BITS-1:0]  shift;

   logic                       fifo_full;
   logic                       fifo_empty;
   logic [7:0]                 fifo_rdata;
   logic                       push;
   logic                       pop;
   logic                       bit_done;

   assign tx_ready = !fifo_full;
   assign push     = tx_valid && tx_ready;
   assign bit_done = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

   // A new frame is fetched either from idle or exactly as a stop bit ends,
   // which gives back-to-back frames with no idle gap.
   assign pop = !fifo_empty &&
                ((state == IDLE_ST) || ((state == STOP_ST) && bit_done));

   uart_tx_fifo #(
      .DATA_W (8),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (tx_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Frame sequencer: txd and tx_busy are registered so the line never glitches
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE_ST;
         clk_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         txd     <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         case (state)
            IDLE_ST: begin
               txd     <= 1'b1;
               tx_busy <= 1'b0;
               clk_cnt <= '0;
               bit_idx <= '0;
               if (pop) begin
                  shift   <= fifo_rdata;
                  txd     <= 1'b0;
                  tx_busy <= 1'b1;
                  state   <= START_ST;
               end
            end

            START_ST: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  txd     <= shift[0];
                  state   <= DATA_ST;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            DATA_ST: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  if (bit_idx != 3'd7) begin
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 1'b1;
                     txd     <= shift[1];
                  end else begin
                     bit_idx <= '0;
                     txd     <= 1'b1;
                     state   <= STOP_ST;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            STOP_ST: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  if (pop) begin
                     shift <= fifo_rdata;
                     txd   <= 1'b0;
                     state <= START_ST;
                  end else begin
                     txd     <= 1'b1;
                     tx_busy <= 1'b0;
                     state   <= IDLE_ST;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            default: begin
               state   <= IDLE_ST;
               clk_cnt <= '0;
               bit_idx <= '0;
               txd     <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit with a 4-entry FIFO.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: producer presents each byte until it sees tx_ready at a falling edge.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       txd;
   logic       tx_busy;
   logic [2:0] fifo_count;

   int errors = 0;
   int checks = 0;

   logic [7:0] ovf_bytes [6] = '{8'h72, 8'h67, 8'h62, 8'h41, 8'h42, 8'h43};
   logic       line_log  [300];
   logic       saw_not_ready;
   logic       will_accept;
   int         idx;

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .txd        (txd),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected line level k cycles into a frame carrying byte b
   function automatic logic exp_line(input logic [7:0] b, input int k);
      int bit_no;
      bit_no = k / CPB;
      if (bit_no == 0) return 1'b0;
      if (bit_no >= 9) return 1'b1;
      return b[bit_no-1];
   endfunction

   initial begin
      // ---------------- reset ----------------
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_txd",   32'(txd), 32'd1);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy",  32'(tx_busy), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_txd",   32'(txd), 32'd1);
         chk("idle_busy",  32'(tx_busy), 32'd0);
         chk("idle_ready", 32'(tx_ready), 32'd1);
         chk("idle_count", 32'(fifo_count), 32'd0);
      end

      // ---------------- single byte 0x72 ----------------
      tx_data  = 8'h72;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("single_count_after_push", 32'(fifo_count), 32'd1);
      chk("single_txd_before_pop",   32'(txd), 32'd1);
      @(negedge clk);
      chk("single_count_after_pop", 32'(fifo_count), 32'd0);
      for (int k = 0; k < 10 * CPB; k++) begin
         chk($sformatf("single_txd_k%0d", k), 32'(txd), 32'(exp_line(8'h72, k)));
         chk("single_busy", 32'(tx_busy), 32'd1);
         @(negedge clk);
      end
      chk("single_busy_end", 32'(tx_busy), 32'd0);
      chk("single_txd_end",  32'(txd), 32'd1);
      repeat (5) @(negedge clk);

      // ---------------- overflow + full-FIFO push/pop race ----------------
      idx           = 0;
      will_accept   = 1'b0;
      saw_not_ready = 1'b0;
      for (int i = 0; i < 260; i++) begin
         line_log[i] = txd;
         if (will_accept) idx++;
         tx_valid = (idx < 6);
         tx_data  = (idx < 6) ? ovf_bytes[idx] : 8'h00;
         if (!tx_ready) saw_not_ready = 1'b1;
         will_accept = tx_valid && tx_ready;
         if (i == 5) begin
            chk("ovf_full_count", 32'(fifo_count), 32'd4);
            chk("ovf_full_ready", 32'(tx_ready), 32'd0);
         end
         if (i == 41) chk("race_pre_count",  32'(fifo_count), 32'd4);
         if (i == 42) begin
            chk("race_pop_count", 32'(fifo_count), 32'(DEPTH - 1));
            chk("race_pop_idx",   32'(idx), 32'd5);
         end
         if (i == 43) chk("race_push_count", 32'(fifo_count), 32'(DEPTH));
         @(negedge clk);
      end
      tx_valid = 1'b0;
      chk("ovf_saw_not_ready", 32'(saw_not_ready), 32'd1);
      chk("ovf_all_accepted",  32'(idx), 32'd6);
      chk("ovf_line_pre0", 32'(line_log[0]), 32'd1);
      chk("ovf_line_pre1", 32'(line_log[1]), 32'd1);
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < 10 * CPB; k++) begin
            chk($sformatf("ovf_f%0d_k%0d", f, k), 32'(line_log[2 + 40 * f + k]),
                32'(exp_line(ovf_bytes[f], k)));
         end
      end
      for (int i = 242; i < 260; i++) begin
         chk("ovf_line_idle", 32'(line_log[i]), 32'd1);
      end
      chk("ovf_busy_end",  32'(tx_busy), 32'd0);
      chk("ovf_count_end", 32'(fifo_count), 32'd0);

      // ---------------- mid-frame reset ----------------
      tx_data  = 8'h67;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'h62;
      @(negedge clk);
      chk("mrst_start_txd", 32'(txd), 32'd0);
      tx_data = 8'h42;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("mrst_queued", 32'(fifo_count), 32'd2);
      repeat (14) @(negedge clk);
      chk("mrst_d2_txd", 32'(txd), 32'd1);
      repeat (2) @(negedge clk);
      chk("mrst_d3_txd", 32'(txd), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_txd",   32'(txd), 32'd1);
      chk("mrst_count", 32'(fifo_count), 32'd0);
      chk("mrst_busy",  32'(tx_busy), 32'd0);
      chk("mrst_ready", 32'(tx_ready), 32'd1);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("mrst_quiet_txd",  32'(txd), 32'd1);
         chk("mrst_quiet_busy", 32'(tx_busy), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
